mips_cpu_regfile_mp: RTL

Parametrised multi-port register file for the MIPS CPU: a configurable number of combinational read ports, one write port with a built-in partial-load merge unit (lb/lbu/lh/lhu/lwl/lwr), and a per-register busy scoreboard for loads whose writeback arrives cycles after issue. It sits between decode (read/claim) and writeback (write/release). It replaces the fixed 2-read file for the multi-cycle and dual-issue datapaths.

---
 rtl/mips_cpu_regfile_mp_if.sv | 29 ++
 rtl/mips_cpu_regfile_mp.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mips_cpu_regfile_mp_if.sv
// Bus bundle for the multi-port MIPS register file.
// master = decode/writeback side, slave = the register file itself.
interface mips_cpu_regfile_mp_if #(
   parameter int ADDR_W = 5,
   parameter int N_READ = 2
);
   logic [N_READ*ADDR_W-1:0] rd_addr;
   logic [N_READ*32-1:0]     rd_data;
   logic [N_READ-1:0]        rd_busy;
   logic                     claim_en;
   logic [ADDR_W-1:0]        claim_addr;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [31:0]              wr_data;
   logic [2:0]               wr_op;
   logic [1:0]               wr_offset;
   logic [ADDR_W:0]          busy_cnt;
   logic [31:0]              regv0;

   modport master (
      output rd_addr, claim_en, claim_addr, wr_en, wr_addr, wr_data, wr_op, wr_offset,
      input  rd_data, rd_busy, busy_cnt, regv0
   );

   modport slave (
      input  rd_addr, claim_en, claim_addr, wr_en, wr_addr, wr_data, wr_op, wr_offset,
      output rd_data, rd_busy, busy_cnt, regv0
   );
endinterface

// File: rtl/mips_cpu_regfile_mp.sv
// Multi-port MIPS register file: N_READ combinational read ports, one write
// port with partial-load merge (lb/lbu/lh/lhu/lwl/lwr) and a per-register
// busy scoreboard for loads in flight.
// Optional macro MIPS_REGFILE_BYPASS_EN: forward the merged write value (and a
// cleared busy bit) to read ports selecting the register being written.
module mips_cpu_regfile_mp #(
   parameter int ADDR_W = 5,
   parameter int N_READ = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   mips_cpu_regfile_mp_if.slave   bus
);
   localparam int DEPTH = 2**ADDR_W;

   localparam logic [2:0] OP_WORD = 3'd0;
   localparam logic [2:0] OP_LB   = 3'd1;
   localparam logic [2:0] OP_LBU  = 3'd2;
   localparam logic [2:0] OP_LH   = 3'd3;
   localparam logic [2:0] OP_LHU  = 3'd4;
   localparam logic [2:0] OP_LWL  = 3'd5;
   localparam logic [2:0] OP_LWR  = 3'd6;

   localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [31:0]          r_mem [DEPTH];
   logic [DEPTH-1:0]     r_busy;
   logic [ADDR_W:0]      r_busy_cnt;

   logic                 w_wr_valid;
   logic                 w_claim_valid;
   logic                 w_inc;
   logic                 w_dec;
   logic [31:0]          w_old;
   logic [31:0]          w_merged;
   logic [7:0]           w_byte;
   logic [15:0]          w_half;
   logic [N_READ*32-1:0] w_rd_data;
   logic [N_READ-1:0]    w_rd_busy;

   // Register 0 is hard-wired: writes and claims to it are dropped here.
   assign w_wr_valid    = bus.wr_en && (bus.wr_addr != '0);
   assign w_claim_valid = bus.claim_en && (bus.claim_addr != '0);
   assign w_old         = r_mem[bus.wr_addr];

   // A busy bit rises only on a claim of an idle register; it falls only when
   // a write releases it and no claim of the same register re-arms it.
   assign w_inc = w_claim_valid && !r_busy[bus.claim_addr];
   assign w_dec = w_wr_valid && r_busy[bus.wr_addr] &&
                  !(w_claim_valid && (bus.claim_addr == bus.wr_addr));

   // Select the byte/half lane addressed by the load offset.
   always_comb begin
      w_byte = bus.wr_data[7:0];
      case (bus.wr_offset)
         2'd0: w_byte = bus.wr_data[7:0];
         2'd1: w_byte = bus.wr_data[15:8];
         2'd2: w_byte = bus.wr_data[23:16];
         2'd3: w_byte = bus.wr_data[31:24];
         default: w_byte = bus.wr_data[7:0];
      endcase
      w_half = bus.wr_offset[1] ? bus.wr_data[31:16] : bus.wr_data[15:0];
   end

   // Merge the raw writeback word with the old register value by load type.
   // A misaligned halfword rewrites the old value, i.e. leaves it unchanged.
   always_comb begin
      w_merged = bus.wr_data;
      case (bus.wr_op)
         OP_LB:  w_merged = {{24{w_byte[7]}}, w_byte};
         OP_LBU: w_merged = {24'h0, w_byte};
         OP_LH:  w_merged = bus.wr_offset[0] ? w_old : {{16{w_half[15]}}, w_half};
         OP_LHU: w_merged = bus.wr_offset[0] ? w_old : {16'h0, w_half};
         OP_LWL: begin
            case (bus.wr_offset)
               2'd0: w_merged = {bus.wr_data[7:0],  w_old[23:0]};
               2'd1: w_merged = {bus.wr_data[15:0], w_old[15:0]};
               2'd2: w_merged = {bus.wr_data[23:0], w_old[7:0]};
               default: w_merged = bus.wr_data;
            endcase
         end
         OP_LWR: begin
            case (bus.wr_offset)
               2'd1: w_merged = {w_old[31:24], bus.wr_data[31:8]};
               2'd2: w_merged = {w_old[31:16], bus.wr_data[31:16]};
               2'd3: w_merged = {w_old[31:8],  bus.wr_data[31:24]};
               default: w_merged = bus.wr_data;
            endcase
         end
         default: w_merged = bus.wr_data;
      endcase
   end

   // Register storage: cleared as a whole on reset, one merged write per edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_wr_valid) begin
         r_mem[bus.wr_addr] <= w_merged;
      end
   end

   // Scoreboard bits: release first, claim last so a same-edge claim wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_busy <= '0;
      end else begin
         if (w_wr_valid)    r_busy[bus.wr_addr]    <= 1'b0;
         if (w_claim_valid) r_busy[bus.claim_addr] <= 1'b1;
      end
   end

   // Population count of busy bits, kept in step with the bit updates.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_busy_cnt <= '0;
      end else begin
         case ({w_inc, w_dec})
            2'b10:   r_busy_cnt <= r_busy_cnt + CNT_ONE;
            2'b01:   r_busy_cnt <= r_busy_cnt - CNT_ONE;
            default: r_busy_cnt <= r_busy_cnt;
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < N_READ; gi++) begin : g_rd
         logic [ADDR_W-1:0] w_addr;
         assign w_addr = bus.rd_addr[gi*ADDR_W +: ADDR_W];
`ifdef MIPS_REGFILE_BYPASS_EN
         logic w_hit;
         assign w_hit = w_wr_valid && (w_addr == bus.wr_addr);
         assign w_rd_data[gi*32 +: 32] = w_hit ? w_merged : r_mem[w_addr];
         assign w_rd_busy[gi] = w_hit ? (w_claim_valid && (bus.claim_addr == bus.wr_addr))
                                      : r_busy[w_addr];
`else
         assign w_rd_data[gi*32 +: 32] = r_mem[w_addr];
         assign w_rd_busy[gi]          = r_busy[w_addr];
`endif
      end
   endgenerate

   assign bus.rd_data  = w_rd_data;
   assign bus.rd_busy  = w_rd_busy;
   assign bus.busy_cnt = r_busy_cnt;
   assign bus.regv0    = r_mem[2];

endmodule
